// File: rtl/sbox_word_scheduler.sv
// Round-robin scheduler that shares one combinational S-box, one byte per cycle, between NUM_REQ word requesters.
// Optional build macro SBOX_SCHED_ROTWORD_EN adds req_rot, which applies RotWord to the word before substitution.
module sbox_word_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_word,
    input  logic [NUM_REQ-1:0]     req_encrypt,
`ifdef SBOX_SCHED_ROTWORD_EN
    input  logic [NUM_REQ-1:0]     req_rot,
`endif
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_word,
    output logic [ID_W-1:0]        resp_id,
    output logic                   sbox_encrypt,
    output logic [7:0]             sbox_byte_in,
    input  logic [7:0]             sbox_byte_out
);

    typedef enum logic [1:0] {IDLE, SUB, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     res_q, res_d;
    logic            enc_q, enc_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_q, last_d;

    logic            found;
    logic [ID_W-1:0] gnt;
    logic [31:0]     sel_word;
    logic            sel_enc;
    logic            sel_rot;

    // Search begins one past the last grant, so the last winner has lowest priority.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cidx;
        found = 1'b0;
        gnt   = '0;
        cand  = 0;
        cidx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cidx = ID_W'(cand);
            if (!found && req_valid[cidx]) begin
                found = 1'b1;
                gnt   = cidx;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        sel_enc  = 1'b1;
        sel_rot  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt == ID_W'(k)) begin
                sel_word = req_word[32*k +: 32];
                sel_enc  = req_encrypt[k];
`ifdef SBOX_SCHED_ROTWORD_EN
                sel_rot  = req_rot[k];
`endif
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        res_d        = res_q;
        enc_d        = enc_q;
        id_d         = id_q;
        last_d       = last_q;
        req_ready    = '0;
        sbox_byte_in = 8'h00;
        sbox_encrypt = 1'b1;
        case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[gnt] = 1'b1;
                    word_d  = sel_rot ? {sel_word[23:0], sel_word[31:24]} : sel_word;
                    enc_d   = sel_enc;
                    id_d    = gnt;
                    last_d  = gnt;
                    idx_d   = 2'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                sbox_encrypt = enc_q;
                // Byte 0 is the most significant byte of the word.
                case (idx_q)
                    2'd0: begin sbox_byte_in = word_q[31:24]; res_d[31:24] = sbox_byte_out; end
                    2'd1: begin sbox_byte_in = word_q[23:16]; res_d[23:16] = sbox_byte_out; end
                    2'd2: begin sbox_byte_in = word_q[15:8];  res_d[15:8]  = sbox_byte_out; end
                    default: begin sbox_byte_in = word_q[7:0]; res_d[7:0]  = sbox_byte_out; end
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            word_q  <= '0;
            res_q   <= '0;
            enc_q   <= 1'b1;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            res_q   <= res_d;
            enc_q   <= enc_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_word  = res_q;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_sbox_word_scheduler.sv
// Directed bench for sbox_word_scheduler with a computed AES S-box model on the shared S-box port.
module tb_sbox_word_scheduler;
    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    logic                  clk;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_word;
    logic [NUM_REQ-1:0]    req_encrypt;
`ifdef SBOX_SCHED_ROTWORD_EN
    logic [NUM_REQ-1:0]    req_rot;
`endif
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_word;
    logic [ID_W-1:0]       resp_id;
    logic                  sbox_encrypt;
    logic [7:0]            sbox_byte_in;
    logic [7:0]            sbox_byte_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    sbox_word_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_word     (req_word),
        .req_encrypt  (req_encrypt),
`ifdef SBOX_SCHED_ROTWORD_EN
        .req_rot      (req_rot),
`endif
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_word    (resp_word),
        .resp_id      (resp_id),
        .sbox_encrypt (sbox_encrypt),
        .sbox_byte_in (sbox_byte_in),
        .sbox_byte_out(sbox_byte_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sbox_byte_out = sbox_encrypt ? fwd_t[sbox_byte_in] : inv_t[sbox_byte_in];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv, s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] f;
            f = aes_sbox(8'(v));
            fwd_t[v] = f;
            inv_t[f] = 8'(v);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("resp_timeout", 32'(ok), 32'd1);
    endtask

    // Called at a falling edge with the scheduler idle.
    task automatic txn(input int k, input logic [31:0] w, input logic enc, input logic [31:0] exp_w);
        req_word[32*k +: 32] = w;
        req_encrypt[k] = enc;
        req_valid = '0;
        req_valid[k] = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk("grant_ready", 32'(req_ready), 32'(1 << k));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            chk("sub_byte_in", 32'(sbox_byte_in), 32'(w[31-8*i -: 8]));
            chk("sub_encrypt", 32'(sbox_encrypt), 32'(enc));
            chk("sub_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_word", resp_word, exp_w);
        chk("resp_id", 32'(resp_id), 32'(k));
        @(negedge clk);
        chk("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_word = '0;
        req_encrypt = '0;
        resp_ready = 1'b0;
`ifdef SBOX_SCHED_ROTWORD_EN
        req_rot = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_word", resp_word, 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_byte_in", 32'(sbox_byte_in), 32'd0);
        chk("rst_encrypt", 32'(sbox_encrypt), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Forward then inverse substitution of the same word.
        txn(0, 32'h00010253, 1'b1, 32'h637c77ed);
        txn(1, 32'h637c77ed, 1'b0, 32'h00010253);

        // Both requesters continuously valid: grants alternate starting at 0.
        req_word = {32'h637c77ed, 32'h00010253};
        req_encrypt = 2'b01;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            bit ok;
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                if (resp_valid === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("rr_timeout", 32'(ok), 32'd1);
            chk("rr_id", 32'(resp_id), 32'(t % 2));
            chk("rr_word", resp_word, (t % 2 == 0) ? 32'h637c77ed : 32'h00010253);
        end
        req_valid = '0;
        @(negedge clk);

        // Back-pressure in RESP with requester 0 still requesting.
        req_word[31:0] = 32'h53020100;
        req_encrypt[0] = 1'b1;
        req_valid = 2'b01;
        resp_ready = 1'b0;
        wait_resp(12);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_word", resp_word, 32'hed777c63);
            chk("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_valid", 32'(resp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("bp_regrant_byte", 32'(sbox_byte_in), 32'h53);
        chk("bp_regrant_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        wait_resp(8);
        chk("bp_second_word", resp_word, 32'hed777c63);
        @(negedge clk);

        // Reset during SUB index 2 discards the transaction.
        req_word[31:0] = 32'h00010253;
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_sub_idx2", 32'(sbox_byte_in), 32'h02);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("mrst_req_ready", 32'(req_ready), 32'd0);
        chk("mrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mrst_resp_word", resp_word, 32'h0);
        chk("mrst_resp_id", 32'(resp_id), 32'd0);
        chk("mrst_byte_in", 32'(sbox_byte_in), 32'd0);
        chk("mrst_encrypt", 32'(sbox_encrypt), 32'd1);
        @(negedge clk);
        chk("mrst_hold_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_resp(8);
        chk("post_rst_id", 32'(resp_id), 32'd0);
        chk("post_rst_word", resp_word, 32'h637c77ed);
        @(negedge clk);

`ifdef SBOX_SCHED_ROTWORD_EN
        // RotWord before SubWord, then plain SubWord on the same word.
        for (int r = 0; r < 2; r++) begin
            req_word[31:0] = 32'h09cf4f3c;
            req_encrypt[0] = 1'b1;
            req_rot = (r == 0) ? 2'b01 : 2'b00;
            req_valid = 2'b01;
            @(posedge clk);
            @(negedge clk);
            req_valid = '0;
            wait_resp(8);
            chk("rot_word", resp_word, (r == 0) ? 32'h8a84eb01 : 32'h018a84eb);
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
